// File: rtl/oled_init_seq.sv
// SSD1306 init byte streamer feeding the i2c master handshake.
// Optional watchdog: define SEQ_TIMEOUT_EN to enable it.
`timescale 1ns/1ps
module oled_init_seq #(
   parameter int NUM_BYTES = 27,
   parameter int IDX_W     = 5
`ifdef SEQ_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 4096
`endif
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start,
   input  logic       next,
   input  logic       trouble,
   output logic       enable,
   output logic [7:0] command,
   output logic       ack,
   output logic       busy,
   output logic       done,
   output logic       error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_HOLD,
      S_DONE,
      S_FAULT
   } state_t;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BYTES - 1);

   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_nxt;
   logic [7:0]       command_nxt;
   logic             enable_nxt;
   logic             ack_nxt;
   logic             busy_nxt;
   logic             done_nxt;
   logic             error_nxt;
   logic             next_q;
   logic             next_rise;
   logic             timeout;
   logic             active;

   function automatic logic [7:0] rom(input logic [IDX_W-1:0] i);
      case (int'(i))
         0:       rom = 8'h78;
         1:       rom = 8'h00;
         2:       rom = 8'hAE;
         3:       rom = 8'hD5;
         4:       rom = 8'h80;
         5:       rom = 8'hA8;
         6:       rom = 8'h3F;
         7:       rom = 8'hD3;
         8:       rom = 8'h00;
         9:       rom = 8'h40;
         10:      rom = 8'h8D;
         11:      rom = 8'h14;
         12:      rom = 8'h20;
         13:      rom = 8'h00;
         14:      rom = 8'hA1;
         15:      rom = 8'hC8;
         16:      rom = 8'hDA;
         17:      rom = 8'h12;
         18:      rom = 8'h81;
         19:      rom = 8'hCF;
         20:      rom = 8'hD9;
         21:      rom = 8'hF1;
         22:      rom = 8'hDB;
         23:      rom = 8'h40;
         24:      rom = 8'hA4;
         25:      rom = 8'hA6;
         26:      rom = 8'hAF;
         default: rom = 8'h00;
      endcase
   endfunction

   assign active    = (state == S_WAIT) || (state == S_HOLD);
   assign next_rise = next && !next_q;

`ifdef SEQ_TIMEOUT_EN
   localparam logic [11:0] WD_LAST = 12'(TIMEOUT_CYCLES - 1);
   logic [11:0] wd;

   // Watchdog restarts on every state change, counts while waiting.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         wd <= '0;
      else if (!active || state_nxt != state)
         wd <= '0;
      else
         wd <= wd + 12'd1;
   end

   assign timeout = active && (wd == WD_LAST);
`else
   assign timeout = 1'b0;
`endif

   // State and registered outputs; next_q tracks the previous next level.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         idx     <= '0;
         command <= 8'h00;
         enable  <= 1'b0;
         ack     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         error   <= 1'b0;
         next_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         idx     <= idx_nxt;
         command <= command_nxt;
         enable  <= enable_nxt;
         ack     <= ack_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
         error   <= error_nxt;
         next_q  <= next;
      end
   end

   // Next-state and output decode; a fault outranks a next edge.
   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      command_nxt = command;
      enable_nxt  = enable;
      ack_nxt     = ack;
      busy_nxt    = busy;
      done_nxt    = 1'b0;
      error_nxt   = error;
      unique case (state)
         S_IDLE, S_DONE, S_FAULT: begin
            if (start) begin
               state_nxt   = S_WAIT;
               idx_nxt     = '0;
               command_nxt = rom('0);
               enable_nxt  = 1'b1;
               ack_nxt     = 1'b0;
               busy_nxt    = 1'b1;
               error_nxt   = 1'b0;
            end
         end
         S_WAIT: begin
            if (trouble || timeout) begin
               state_nxt  = S_FAULT;
               enable_nxt = 1'b0;
               ack_nxt    = 1'b0;
               busy_nxt   = 1'b0;
               error_nxt  = 1'b1;
            end else if (next_rise) begin
               if (idx == LAST) begin
                  state_nxt  = S_DONE;
                  enable_nxt = 1'b0;
                  busy_nxt   = 1'b0;
                  done_nxt   = 1'b1;
               end else begin
                  state_nxt   = S_HOLD;
                  idx_nxt     = idx + IDX_W'(1);
                  command_nxt = rom(idx + IDX_W'(1));
                  ack_nxt     = 1'b1;
               end
            end
         end
         S_HOLD: begin
            if (trouble || timeout) begin
               state_nxt  = S_FAULT;
               enable_nxt = 1'b0;
               ack_nxt    = 1'b0;
               busy_nxt   = 1'b0;
               error_nxt  = 1'b1;
            end else if (!next) begin
               state_nxt = S_WAIT;
               ack_nxt   = 1'b0;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_oled_init_seq.sv
// Directed/randomized bench for oled_init_seq with a byte-list model.
// Build with SEQ_TIMEOUT_EN to exercise the 64-cycle watchdog.
`timescale 1ns/1ps
module tb_oled_init_seq;

   localparam int NB = 27;

   logic       clock;
   logic       reset_n;
   logic       start;
   logic       next;
   logic       trouble;
   logic       enable;
   logic [7:0] command;
   logic       ack;
   logic       busy;
   logic       done;
   logic       error;

   int vectors    = 0;
   int miscompares = 0;
   int ack_cnt    = 0;
   int done_cnt   = 0;
   logic ack_d    = 1'b0;

   logic [7:0] rom_m [NB] = '{
      8'h78, 8'h00, 8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F,
      8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14, 8'h20, 8'h00,
      8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9,
      8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
   };

`ifdef SEQ_TIMEOUT_EN
   oled_init_seq #(.TIMEOUT_CYCLES(64)) dut (
      .clock(clock), .reset_n(reset_n), .start(start),
      .next(next), .trouble(trouble), .enable(enable),
      .command(command), .ack(ack), .busy(busy),
      .done(done), .error(error)
   );
`else
   oled_init_seq dut (
      .clock(clock), .reset_n(reset_n), .start(start),
      .next(next), .trouble(trouble), .enable(enable),
      .command(command), .ack(ack), .busy(busy),
      .done(done), .error(error)
   );
`endif

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (ack && !ack_d) ack_cnt++;
      ack_d = ack;
      if (done) done_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout observed=running required=finished");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_en", enable, 1);
      chk("start_busy", busy, 1);
      chk("start_err", error, 0);
      chk("start_cmd", command, 8'h78);
      chk("start_ack", ack, 0);
   endtask

   // Master model: consume byte k, optionally stop while ack is high.
   task automatic serve(input int k, input bit stop_in_hold);
      int d;
      int h;
      chk("cmd", command, rom_m[k]);
      chk("en", enable, 1);
      d = $urandom_range(1, 6);
      repeat (d - 1) tick();
      next = 1'b1;
      tick();
      if (k < NB - 1) begin
         chk("ack_up", ack, 1);
         chk("cmd_nx", command, rom_m[k+1]);
         if (stop_in_hold) return;
         h = $urandom_range(0, 3);
         repeat (h) begin
            tick();
            chk("ack_hold", ack, 1);
         end
         next = 1'b0;
         tick();
         chk("ack_dn", ack, 0);
         chk("cmd_stable", command, rom_m[k+1]);
      end else begin
         chk("done", done, 1);
         chk("en_off", enable, 0);
         chk("busy_off", busy, 0);
         next = 1'b0;
         tick();
         chk("done_1cyc", done, 0);
      end
   endtask

   task automatic full_run(input string tag);
      int a0;
      int d0;
      a0 = ack_cnt;
      d0 = done_cnt;
      do_start();
      for (int k = 0; k < NB; k++) serve(k, 1'b0);
      tick();
      chk({tag, "_acks"}, ack_cnt - a0, NB - 1);
      chk({tag, "_dones"}, done_cnt - d0, 1);
      chk({tag, "_en"}, enable, 0);
      chk({tag, "_last"}, command, rom_m[NB-1]);
      chk({tag, "_err"}, error, 0);
   endtask

   initial begin
      int t;
      int d0;
      int n;
      reset_n = 1'b0;
      start   = 1'b0;
      next    = 1'b0;
      trouble = 1'b0;
      repeat (3) tick();
      chk("rst_en", enable, 0);
      chk("rst_cmd", command, 8'h00);
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", error, 0);
      reset_n = 1'b1;
      repeat (2) tick();

      full_run("run1");

      t = $urandom_range(2, 24);
      d0 = done_cnt;
      do_start();
      for (int k = 0; k < t; k++) serve(k, 1'b0);
      trouble = 1'b1;
      tick();
      trouble = 1'b0;
      chk("flt_en", enable, 0);
      chk("flt_err", error, 1);
      chk("flt_busy", busy, 0);
      chk("flt_cmd", command, rom_m[t]);
      repeat (3) tick();
      chk("flt_sticky", error, 1);
      chk("flt_nodone", done_cnt - d0, 0);
      full_run("run2");

      t = $urandom_range(0, 24);
      do_start();
      for (int k = 0; k < t; k++) serve(k, 1'b0);
      serve(t, 1'b1);
      trouble = 1'b1;
      tick();
      trouble = 1'b0;
      next = 1'b0;
      chk("hflt_ack", ack, 0);
      chk("hflt_err", error, 1);
      chk("hflt_cmd", command, rom_m[t+1]);
      tick();

      t = $urandom_range(1, 24);
      d0 = ack_cnt;
      do_start();
      for (int k = 0; k < t; k++) serve(k, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("sb_cmd", command, rom_m[t]);
      chk("sb_en", enable, 1);
      for (int k = t; k < NB; k++) serve(k, 1'b0);
      tick();
      chk("sb_acks", ack_cnt - d0, NB - 1);

      t = $urandom_range(0, 20);
      do_start();
      for (int k = 0; k < t; k++) serve(k, 1'b0);
      serve(t, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("ar_en", enable, 0);
      chk("ar_ack", ack, 0);
      chk("ar_busy", busy, 0);
      chk("ar_cmd", command, 8'h00);
      chk("ar_err", error, 0);
      next = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      full_run("run3");

      t = $urandom_range(0, 24);
      do_start();
      for (int k = 0; k < t; k++) serve(k, 1'b0);
      next = 1'b1;
      trouble = 1'b1;
      tick();
      next = 1'b0;
      trouble = 1'b0;
      chk("nt_en", enable, 0);
      chk("nt_err", error, 1);
      chk("nt_ack", ack, 0);
      chk("nt_cmd", command, rom_m[t]);
      tick();
      chk("nt_ack2", ack, 0);

      do_start();
`ifdef SEQ_TIMEOUT_EN
      n = 0;
      while (enable && n < 200) begin
         tick();
         n++;
      end
      chk("wd_cycles", n, 64);
      chk("wd_err", error, 1);
      chk("wd_busy", busy, 0);
`else
      n = 0;
      repeat (1000) begin
         tick();
         if (busy) n++;
      end
      chk("nowd_busy", n, 1000);
      chk("nowd_en", enable, 1);
      trouble = 1'b1;
      tick();
      trouble = 1'b0;
      chk("nowd_exit", error, 1);
`endif
      tick();
      full_run("run4");

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
